// File: rtl/div_pkg.sv
// Shared definitions for the iterative MIPS DIV/DIVU divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   diff;

  always_comb begin
    rem_sh   = {rem[WIDTH-2:0], dvd_bit};
    diff     = {1'b0, rem_sh} - {1'b0, divisor};
    // A bit shifted out of the top means rem' >= 2^WIDTH > divisor, so it must subtract.
    q_bit    = rem[WIDTH-1] | ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : rem_sh;
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider: quotient to LO (Q), remainder to HI (R).
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvs_q, rem_q, q_q, r_q;
  logic [CntW-1:0]  cnt_q;
  logic             sign_q_q, sign_r_q, zero_q, done_q, div_zero_q;

  logic [WIDTH-1:0] a_mag, b_mag, step_rem;
  logic             step_q;

  assign a_mag = (Signed && A[WIDTH-1]) ? -A : A;
  assign b_mag = (Signed && B[WIDTH-1]) ? -B : B;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem_q),
    .dvd_bit (dvd_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_next(step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (B == '0) ? FIX : CALC;
      CALC:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  assign done     = done_q;
  assign Q        = q_q;
  assign R        = r_q;
  assign div_zero = div_zero_q;

  // Quotient bits shift into the dividend register as its bits are consumed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      sign_q_q   <= 1'b0;
      sign_r_q   <= 1'b0;
      zero_q     <= 1'b0;
      done_q     <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sign_q_q <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            sign_r_q <= Signed & A[WIDTH-1];
            zero_q   <= (B == '0);
            dvd_q    <= (B == '0) ? A : a_mag;
            dvs_q    <= b_mag;
            rem_q    <= '0;
            cnt_q    <= CntW'(WIDTH - 1);
          end
        end
        CALC: begin
          rem_q <= step_rem;
          dvd_q <= {dvd_q[WIDTH-2:0], step_q};
          cnt_q <= cnt_q - CntW'(1);
        end
        FIX: begin
          done_q     <= 1'b1;
          div_zero_q <= zero_q;
          if (zero_q) begin
            q_q <= DIV_ZERO_Q;
            r_q <= dvd_q;
          end else begin
            q_q <= sign_q_q ? -dvd_q : dvd_q;
            r_q <= sign_r_q ? -rem_q : rem_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        Signed = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done, div_zero;
  logic [31:0] Q, R;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  div_unit u_dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .Signed  (Signed),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .Q       (Q),
    .R       (R),
    .div_zero(div_zero)
  );

  // Present operands and hold start across one rising edge; returns #1 after that edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    A = a; B = b; Signed = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Edges after the launch edge until done, and how many samples showed busy.
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) bc++;
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, div_zero} !== 3'b000 || Q !== 32'd0 || R !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b dz=%b Q=%h R=%h, want all zero",
               busy, done, div_zero, Q, R);
    end
    reset = 1'b1;
  endtask

  task automatic test_divide;
    logic [31:0] ta [7] = '{32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9,
                            32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] tb [7] = '{32'd7, 32'd1, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                            32'hFFFF_FFFF, 32'h8000_0001};
    logic        ts [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] eq [7] = '{32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3,
                            32'h8000_0000, 32'd1};
    logic [31:0] er [7] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0,
                            32'h7FFF_FFFE};
    int lat, bc;
    for (int i = 0; i < 7; i++) begin
      launch(ta[i], tb[i], ts[i]);
      wait_done(lat, bc);
      vectors++;
      if (lat !== 33 || bc !== 33 || busy !== 1'b0) begin
        errors++;
        $display("FAIL div%0d_timing: lat=%0d busy_cycles=%0d busy=%b, want 33/33/0",
                 i, lat, bc, busy);
      end
      vectors++;
      if (Q !== eq[i] || R !== er[i] || div_zero !== 1'b0) begin
        errors++;
        $display("FAIL div%0d_result: Q=%h R=%h dz=%b, want Q=%h R=%h dz=0",
                 i, Q, R, div_zero, eq[i], er[i]);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (done !== 1'b0 || Q !== eq[i]) begin
        errors++;
        $display("FAIL div%0d_pulse_hold: done=%b Q=%h, want done=0 Q=%h", i, done, Q, eq[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat, bc;
    launch(32'd5, 32'd0, 1'b0);
    wait_done(lat, bc);
    vectors++;
    if (lat !== 1 || bc !== 1 || Q !== 32'hFFFF_FFFF || R !== 32'd5 || div_zero !== 1'b1) begin
      errors++;
      $display("FAIL div_zero: lat=%0d busy=%0d Q=%h R=%h dz=%b, want 1/1 FFFFFFFF 5 1",
               lat, bc, Q, R, div_zero);
    end
    launch(32'd9, 32'd3, 1'b0);
    wait_done(lat, bc);
    vectors++;
    if (lat !== 33 || Q !== 32'd3 || R !== 32'd0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL after_zero: lat=%0d Q=%h R=%h dz=%b, want 33 3 0 0", lat, Q, R, div_zero);
    end
  endtask

  task automatic test_start_while_busy;
    int dones = 0;
    int t_done = -1;
    launch(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    A = 32'd1000; B = 32'd3; Signed = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int t = 10; t < 45; t++) begin
      if (done === 1'b1) begin
        dones++;
        if (t_done < 0) t_done = t;
      end
      if (t == 10) begin
        vectors++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_restart: busy=%b at edge k+10, want 1", busy);
        end
      end
      if (t == 33) begin
        vectors++;
        if (Q !== 32'd14 || R !== 32'd2) begin
          errors++;
          $display("FAIL busy_result: Q=%h R=%h, want Q=e R=2", Q, R);
        end
      end
      @(posedge clk);
      #1;
    end
    vectors++;
    if (dones !== 1 || t_done !== 33) begin
      errors++;
      $display("FAIL busy_done_count: dones=%0d first_at=%0d, want 1 at 33", dones, t_done);
    end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    int lat, bc;
    launch(32'd100, 32'd7, 1'b0);
    repeat (14) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, div_zero} !== 3'b000 || Q !== 32'd0 || R !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b dz=%b Q=%h R=%h, want all zero",
               busy, done, div_zero, Q, R);
    end
    reset = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL mid_reset_quiet: %0d cycles busy/done after reset, want 0", dones);
    end
    launch(32'd50, 32'd5, 1'b0);
    wait_done(lat, bc);
    vectors++;
    if (lat !== 33 || Q !== 32'd10 || R !== 32'd0) begin
      errors++;
      $display("FAIL after_reset: lat=%0d Q=%h R=%h, want 33 a 0", lat, Q, R);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    launch(32'd17, 32'd5, 1'b0);
    wait_done(lat, bc);
    // Request the next op in the done cycle itself.
    A = 32'hFFFF_FFEC; B = 32'd6; Signed = 1'b1; start = 1'b1;
    vectors++;
    if (lat !== 33 || Q !== 32'd3 || R !== 32'd2) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d Q=%h R=%h, want 33 3 2", lat, Q, R);
    end
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc);
    vectors++;
    if (lat !== 33 || bc !== 33 || Q !== 32'hFFFF_FFFD || R !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d busy=%0d Q=%h R=%h, want 33/33 FFFFFFFD FFFFFFFE",
               lat, bc, Q, R);
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div_zero();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle integer divider for the ALU's MIPS DIV/DIVU path: it computes the inverse of the multiply operation by repeated conditional subtraction. The Arith block provides single-cycle add and subtract; this block provides the iterative divide. It sits beside the ALU and writes quotient to LO and remainder to HI. It stalls the pipeline through a start/busy/done handshake.

## Interface
- WIDTH, 32, operand/result width in bits.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; sampled on rising edge of clk.
- start  in  1  request; operands sampled when high in IDLE.
- Signed  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- A  in  WIDTH  dividend.
- B  in  WIDTH  divisor.
- busy  out  1  high while a division is in flight.
- done  out  1  one-cycle pulse; Q/R/div_zero valid from that cycle on.
- Q  out  WIDTH  quotient (to LO).
- R  out  WIDTH  remainder (to HI).
- div_zero  out  1  last completed operation had B == 0.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 and B≠0: latch |A|, |B| (magnitudes if Signed, raw otherwise). Latch sign_q = A[31]^B[31] and sign_r = A[31] (both forced 0 if unsigned). Clear partial remainder and count=WIDTH-1. Go to CALC.
  - start=1 and B==0: go directly to FIX with div_zero flag set.
- CALC, one restoring step per cycle:
  - rem' = {rem[WIDTH-2:0], dividend MSB}; shift dividend left.
  - If rem' ≥ divisor, subtract and shift in quotient bit 1, else shift in 0.
  - count decrements; on count==0, go to FIX.
- FIX:
  - Q = sign_q ? −q : q; R = sign_r ? −rem : rem.
  - Semantics: quotient truncates toward zero; remainder takes the dividend's sign.
  - Div-by-zero: Q = all-ones, R = A (raw), div_zero = 1.
  - Otherwise div_zero = 0.
  - done=1, return to IDLE.
- Width rules:
  - Magnitudes and the partial remainder are WIDTH bits unsigned. |0x80000000| = 0x80000000 fits.
  - The comparison uses a WIDTH+1-bit subtract so that carry-out is the ≥ result.
- Signed 0x80000000 / −1: no special case. The result is Q=0x80000000, R=0, with no flag.
- start while busy: ignored, and operands are not resampled.
- Q, R and div_zero hold their values until the next FIX.

## Timing
- Reset values: busy=0, done=0, Q=0, R=0, div_zero=0, state=IDLE.
- Normal case, start sampled at edge k:
  - busy=1 after edge k through edge k+32 (33 cycles).
  - Iterations occur at edges k+1..k+32.
  - At edge k+33: FIX registers Q/R, done=1 for exactly one cycle, busy=0.
- Divide-by-zero, start at edge k: busy=1 for one cycle. At edge k+1, done=1 and div_zero=1.
- Back-to-back: start may be high in the cycle done is high. It is accepted at the next edge because state is IDLE.
- Reset low at any edge mid-operation: return to IDLE, and all outputs take their reset values at that edge. No done pulse is produced.

## Structure
- Shared package div_pkg:
  - state enum {IDLE, CALC, FIX};
  - DIV_WIDTH = 32;
  - DIV_ZERO_Q = all-ones constant.
- Sub-module div_step: combinational single iteration.
  - Inputs: rem, next dividend bit, divisor.
  - Outputs: new rem, quotient bit.
  - Instantiated once inside div_unit; the FSM, counter and sign fixup stay in the top.

## Test plan
- Unsigned 100/7 (Signed=0, start at edge k): busy for 33 cycles; done at edge k+33 with Q=14, R=2, div_zero=0.
- Signed −7/2 (A=0xFFFFFFF9, B=2): Q=0xFFFFFFFD (−3), R=0xFFFFFFFF (−1). Signed 7/−2: Q=0xFFFFFFFD, R=1.
- Signed 0x80000000/0xFFFFFFFF: Q=0x80000000, R=0. Unsigned 0xFFFFFFFF/1: Q=0xFFFFFFFF, R=0.
- Divide-by-zero, 5/0: done at edge k+1, Q=0xFFFFFFFF, R=5, div_zero=1. A following 9/3 gives Q=3, R=0, div_zero=0.
- start pulsed at edge k+10 with different operands during busy: ignored; the result matches the original operands, with exactly one done pulse.
- reset driven low at edge k+15, released after one cycle: busy=0, Q=R=0, no done. A new 50/5 started afterwards gives Q=10, R=0 after 33 cycles.
